neureka_tcdm_responder: RTL and testbench
=========================================

NEUREKA_TCDM_RESPONDER -- requirements
Module: neureka_tcdm_responder

Interface
REQ-001 SHALL have parameter MP, default 4: number of 32-bit TCDM slave ports.
REQ-002 SHALL have parameter NB, default 8: number of word-interleaved banks; power of 2, NB >= 1.
REQ-003 SHALL have parameter DEPTH, default 256: 32-bit words per bank; power of 2.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port tcdm_req  in  MP  per-port request.
REQ-007 SHALL have port tcdm_gnt  out  MP  per-port grant, combinational in the request cycle.
REQ-008 SHALL have port tcdm_add  in  MPx32  byte address.
REQ-009 SHALL have port tcdm_wen  in  MP  1 = read, 0 = write.
REQ-010 SHALL have port tcdm_be  in  MPx4  byte enables for writes.
REQ-011 SHALL have port tcdm_data  in  MPx32  write data.
REQ-012 SHALL have port tcdm_r_data  out  MPx32  response data.
REQ-013 SHALL have port tcdm_r_valid  out  MP  response valid.
REQ-014 SHALL have port stall_i  in  MP  bench stall injection; 1 forces tcdm_gnt low for that port.

Function
REQ-015 SHALL decode each request from the address: bank = add[2 +: log2(NB)], row = add[2+log2(NB) +: log2(DEPTH)].
REQ-016 SHALL ignore add[1:0] and all address bits above the row field, so the address space wraps modulo NB*DEPTH*4 bytes.
REQ-017 SHALL treat a port as eligible when tcdm_req=1 and stall_i=0.
REQ-018 SHALL grant at most one eligible port per bank per cycle.
REQ-019 SHALL grant requests to different banks in the same cycle independently, with no interaction between them.
REQ-020 SHALL arbitrate each bank round-robin.
- Each bank keeps a priority pointer p in 0..MP-1.
- The grant goes to the first eligible port found scanning p, p+1, ..., wrapping mod MP.
- After a grant to port k, p becomes (k+1) mod MP.
- p is unchanged in cycles with no grant for that bank.
REQ-021 SHALL hold tcdm_gnt low for every non-eligible port.
REQ-022 SHALL perform a granted write on the clock edge that ends the grant cycle: each byte i with be[i]=1 takes data[8i+7:8i]; bytes with be[i]=0 keep their value.
REQ-023 SHALL assert tcdm_r_valid for port k for exactly one cycle, in the cycle immediately after every granted request of port k (read or write), giving a fixed latency of 1.
REQ-024 SHALL present, in the response cycle of a granted read, the row content as it was before any write granted in that same grant cycle.
- Only one access per bank per cycle is possible, so no same-bank conflict exists within a grant cycle.
REQ-025 SHALL return the new data when a read is granted in the cycle after a write to the same word (read-after-write, no hazard).
REQ-026 SHALL drive tcdm_r_data = 0 in the response cycle of a granted write.
REQ-027 SHALL drive tcdm_r_data = 0 in every cycle where tcdm_r_valid = 0.
REQ-028 SHALL support back-to-back grants to one port on consecutive cycles, giving continuous r_valid with no bubble.
REQ-029 SHALL not require the master to keep req high after a grant.
REQ-030 SHALL keep no state for a request that was not granted; the master re-presents it.

Reset
REQ-031 SHALL, while rst_i=1, drive tcdm_gnt=0, tcdm_r_valid=0 and tcdm_r_data=0, and set all bank pointers to 0.
REQ-032 SHALL leave memory contents unaffected by reset.
REQ-033 SHALL perform no write for any request present while rst_i=1.
REQ-034 SHALL cancel a response pending from the cycle before reset, so no r_valid appears in or after the reset cycle.
REQ-035 SHALL let the first grant after reset release favour port 0 on every bank.

Verification
REQ-036 Single access: port0 writes 0xDEADBEEF at 0x40 with be=0xF, then reads 0x40 -> gnt=1 on both; r_valid one cycle after each; read returns 0xDEADBEEF; the write response has r_data=0.
REQ-037 Byte enables: write 0xFFFFFFFF, then 0x00000000 with be=0x5 to the same address, then read -> 0xFF00FF00.
REQ-038 Bank conflict: all 4 ports read 0x00 every cycle after reset -> grants go port0,1,2,3,0 on cycles 1..5; one r_valid per cycle in that same order, delayed by 1 cycle.
REQ-039 Parallel banks: ports 0..3 read 0x00, 0x04, 0x08, 0x0C in the same cycle -> all four granted; all r_valid=1 on the next cycle.
REQ-040 Wrap and stall: with NB=8, DEPTH=256, write at 0x2000 and read at 0x0000 -> same word returned. Holding stall_i[0]=1 keeps gnt[0]=0 with req high; releasing it grants on the next cycle.
REQ-041 Reset mid-operation: assert rst_i in the cycle right after a granted read -> r_valid stays 0; memory keeps its value; pointers return to 0.

Source files
------------

// File: rtl/neureka_tcdm_responder.sv
// rtl/neureka_tcdm_responder.sv - multi-port word-interleaved TCDM memory responder
//
// Purpose: MP 32-bit TCDM slave ports share NB word-interleaved banks of DEPTH
// words each. Every bank runs its own round-robin arbiter. Grants are
// combinational in the request cycle. Responses always arrive exactly one
// cycle after the grant.
//
// Ports:
//   clk_i, rst_i  : clock and synchronous active-high reset
//   tcdm_req      : per-port request
//   tcdm_gnt      : per-port grant, combinational
//   tcdm_add      : byte address; bank and row are decoded from word bits
//   tcdm_wen      : 1 = read, 0 = write
//   tcdm_be       : write byte enables
//   tcdm_data     : write data
//   tcdm_r_data   : response data; zero for writes and for idle cycles
//   tcdm_r_valid  : one-cycle response strobe
//   stall_i       : forces the grant low for that port
module neureka_tcdm_responder #(
    parameter int MP    = 4,
    parameter int NB    = 8,
    parameter int DEPTH = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MP-1:0]        tcdm_req,
    output logic [MP-1:0]        tcdm_gnt,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][3:0]   tcdm_be,
    input  logic [MP-1:0][31:0]  tcdm_data,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic [MP-1:0]        tcdm_r_valid,
    input  logic [MP-1:0]        stall_i
);

    localparam int NB_LOG = $clog2(NB);
    localparam int BW     = (NB > 1) ? NB_LOG : 1;
    localparam int RW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW     = (MP > 1) ? $clog2(MP) : 1;

    logic [31:0]          mem [NB][DEPTH];
    logic [PW-1:0]        ptr_q [NB];
    logic [BW-1:0]        bank_of [MP];
    logic [RW-1:0]        row_of [MP];
    logic [MP-1:0]        elig;
    logic [MP-1:0]        gnt_c;
    logic [NB-1:0]        bank_gnt;
    logic [PW-1:0]        bank_sel [NB];
    logic [MP-1:0]        rvalid_q;
    logic [MP-1:0][31:0]  rdata_q;

    // Port index visited at scan step i when the bank's pointer is p.
    function automatic int rr_idx(input int p, input int i);
        return (p + i) % MP;
    endfunction

    // Address decode: byte offset and bits above the row field are dropped,
    // so the address space aliases every NB*DEPTH words.
    always_comb begin
        for (int k = 0; k < MP; k++) begin
            bank_of[k] = (NB > 1) ? tcdm_add[k][2 +: BW] : '0;
            row_of[k]  = (DEPTH > 1) ? tcdm_add[k][2 + NB_LOG +: RW] : '0;
        end
    end

    // Reset masks eligibility, which suppresses grants and writes together.
    assign elig = tcdm_req & ~stall_i & {MP{~rst_i}};

    // Per-bank round-robin: first eligible port targeting this bank, scanning
    // upward from the bank's pointer. A port addresses a single bank, so the
    // per-bank grants never collide on the same port.
    always_comb begin
        gnt_c    = '0;
        bank_gnt = '0;
        for (int b = 0; b < NB; b++) begin
            bank_sel[b] = '0;
            for (int i = 0; i < MP; i++) begin
                if (!bank_gnt[b] && elig[rr_idx(int'(ptr_q[b]), i)] &&
                    int'(bank_of[rr_idx(int'(ptr_q[b]), i)]) == b) begin
                    bank_gnt[b] = 1'b1;
                    bank_sel[b] = PW'(rr_idx(int'(ptr_q[b]), i));
                    gnt_c[rr_idx(int'(ptr_q[b]), i)] = 1'b1;
                end
            end
        end
    end

    assign tcdm_gnt = gnt_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NB; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_gnt[b]) begin
                    ptr_q[b] <= PW'((int'(bank_sel[b]) + 1) % MP);
                end
            end
        end
    end

    // Memory is deliberately outside reset so its contents survive it.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_gnt[b] && !tcdm_wen[bank_sel[b]]) begin
                for (int i = 0; i < 4; i++) begin
                    if (tcdm_be[bank_sel[b]][i]) begin
                        mem[b][row_of[bank_sel[b]]][8*i +: 8] <= tcdm_data[bank_sel[b]][8*i +: 8];
                    end
                end
            end
        end
    end

    // The read samples the array before this edge's write lands, giving
    // pre-write data in the response and new data to a read one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int k = 0; k < MP; k++) begin
                rvalid_q[k] <= gnt_c[k];
                rdata_q[k]  <= (gnt_c[k] && tcdm_wen[k]) ? mem[bank_of[k]][row_of[k]] : 32'h0;
            end
        end
    end

    // Masking the outputs with rst_i cancels a response already in flight
    // when reset arrives.
    always_comb begin
        for (int k = 0; k < MP; k++) begin
            tcdm_r_valid[k] = rvalid_q[k] & ~rst_i;
            tcdm_r_data[k]  = rst_i ? 32'h0 : rdata_q[k];
        end
    end

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// tb/tb_neureka_tcdm_responder.sv - directed scoreboard bench for neureka_tcdm_responder
module tb_neureka_tcdm_responder;

    localparam int MP = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] wdata;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;
    logic [MP-1:0]       stall;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [2048];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;

    always #5 clk = ~clk;

    neureka_tcdm_responder #(.MP(MP), .NB(8), .DEPTH(256)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tcdm_req     (req),
        .tcdm_gnt     (gnt),
        .tcdm_add     (add),
        .tcdm_wen     (wen),
        .tcdm_be      (be),
        .tcdm_data    (wdata),
        .tcdm_r_data  (r_data),
        .tcdm_r_valid (r_valid),
        .stall_i      (stall)
    );

    task automatic clear_ports();
        req   = '0;
        wen   = '1;
        add   = '0;
        be    = '0;
        wdata = '0;
        stall = '0;
    endtask

    task automatic set_port(input int k, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
        req[k]   = 1'b1;
        wen[k]   = w;
        add[k]   = a;
        be[k]    = b;
        wdata[k] = d;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: compare this cycle's grant and responses, then book
    // the responses owed next cycle for each port expected to be granted.
    task automatic do_cycle(input logic [MP-1:0] eg, input string tag);
        logic [MP-1:0]       ev;
        logic [MP-1:0][31:0] ed;
        logic [31:0]         d;
        logic [10:0]         widx;
        exp_t                e;
        @(negedge clk);
        ev = '0;
        ed = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
            e = exp_q.pop_front();
            if (!rst) begin
                ev[e.port] = 1'b1;
                ed[e.port] = e.data;
            end
        end
        if (rst) exp_q.delete();
        check({tag, "/gnt"},    128'(gnt),     128'(eg));
        check({tag, "/rvalid"}, 128'(r_valid), 128'(ev));
        check({tag, "/rdata"},  128'(r_data),  128'(ed));
        for (int k = 0; k < MP; k++) begin
            if (eg[k] && !rst) begin
                widx = add[k][12:2];
                if (wen[k]) begin
                    d = model[widx];
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[k][i]) model[widx][8*i +: 8] = wdata[k][8*i +: 8];
                    end
                    d = 32'h0;
                end
                exp_q.push_back('{cyc: cyc_n + 1, port: k, data: d});
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        rst = 1'b1;
        clear_ports();
        set_port(0, 1'b0, 32'h40, 4'hF, 32'h1111_1111);
        do_cycle(4'b0000, "rst0");
        do_cycle(4'b0000, "rst1");
        rst = 1'b0;

        // Single write then read of 0x40.
        clear_ports(); set_port(0, 1'b0, 32'h40, 4'hF, 32'hDEAD_BEEF);
        do_cycle(4'b0001, "wr40");
        clear_ports(); set_port(0, 1'b1, 32'h40, 4'h0, 32'h0);
        do_cycle(4'b0001, "rd40");
        clear_ports();
        do_cycle(4'b0000, "rd40_rsp");

        // Byte enables.
        clear_ports(); set_port(1, 1'b0, 32'h44, 4'hF, 32'hFFFF_FFFF);
        do_cycle(4'b0010, "be_full");
        clear_ports(); set_port(1, 1'b0, 32'h44, 4'h5, 32'h0000_0000);
        do_cycle(4'b0010, "be_part");
        clear_ports(); set_port(1, 1'b1, 32'h44, 4'h0, 32'h0);
        do_cycle(4'b0010, "be_rd");
        clear_ports();
        do_cycle(4'b0000, "be_rsp");

        // Fill banks 0..3, then read them back in parallel.
        clear_ports();
        for (int k = 0; k < MP; k++) set_port(k, 1'b0, 32'(4 * k), 4'hF, 32'hA0B0_C000 + 32'(k));
        do_cycle(4'b1111, "par_wr");
        clear_ports();
        for (int k = 0; k < MP; k++) set_port(k, 1'b1, 32'(4 * k), 4'h0, 32'h0);
        do_cycle(4'b1111, "par_rd");
        clear_ports();
        do_cycle(4'b0000, "par_rsp");

        // Bank conflict right after reset: grants rotate from port 0.
        rst = 1'b1;
        do_cycle(4'b0000, "rst2");
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clear_ports();
            for (int k = 0; k < MP; k++) set_port(k, 1'b1, 32'h0, 4'h0, 32'h0);
            do_cycle(4'(1 << (c % MP)), "conflict");
        end
        clear_ports();
        do_cycle(4'b0000, "conflict_rsp");

        // Reset right after a granted read; a write presented during reset is dropped.
        clear_ports(); set_port(0, 1'b1, 32'h40, 4'h0, 32'h0);
        do_cycle(4'b0001, "pre_rst_rd");
        rst = 1'b1;
        clear_ports(); set_port(2, 1'b0, 32'h40, 4'hF, 32'h1234_5678);
        do_cycle(4'b0000, "rst_mid");
        rst = 1'b0;
        clear_ports();
        set_port(1, 1'b1, 32'h40, 4'h0, 32'h0);
        set_port(0, 1'b1, 32'h40, 4'h0, 32'h0);
        do_cycle(4'b0001, "ptr_reset");
        clear_ports();
        do_cycle(4'b0000, "ptr_reset_rsp");

        // Address wrap: 0x2000 aliases 0x0000.
        clear_ports(); set_port(3, 1'b0, 32'h2000, 4'hF, 32'hCAFE_F00D);
        do_cycle(4'b1000, "wrap_wr");
        clear_ports(); set_port(2, 1'b1, 32'h0000, 4'h0, 32'h0);
        do_cycle(4'b0100, "wrap_rd");

        // Stall holds the grant low until released.
        clear_ports(); set_port(0, 1'b1, 32'h0, 4'h0, 32'h0); stall[0] = 1'b1;
        do_cycle(4'b0000, "stall0");
        do_cycle(4'b0000, "stall1");
        stall[0] = 1'b0;
        do_cycle(4'b0001, "stall_rel");

        // Back-to-back grants to one port.
        for (int c = 0; c < 3; c++) begin
            clear_ports(); set_port(1, 1'b1, 32'h04, 4'h0, 32'h0);
            do_cycle(4'b0010, "b2b");
        end
        clear_ports();
        do_cycle(4'b0000, "b2b_rsp");
        do_cycle(4'b0000, "idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
